// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the riscv_mem arbiter: size encodings, FSM states and requester ids.
package riscv_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

  // The reserved size code 11 behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'b11) ? SZ_WORD : sz;
  endfunction

endpackage

// File: rtl/riscv_mem_lane.sv
// Combinational lane logic: misalignment check, store byte-lane steering, load shift and extension.
module riscv_mem_lane
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic        misaligned,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [1:0]  sz;
  logic [31:0] shifted;

  always_comb begin
    sz         = norm_size(size);
    shifted    = rdata_raw >> {addr_lo, 3'b000};
    misaligned = 1'b0;
    wdata_lane = wdata;
    rdata_ext  = shifted;
    case (sz)
      SZ_BYTE: begin
        wdata_lane = {24'd0, wdata[7:0]} << {addr_lo, 3'b000};
        rdata_ext  = {{24{~uns & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        misaligned = addr_lo[0];
        wdata_lane = {16'd0, wdata[15:0]} << {addr_lo[1], 4'b0000};
        rdata_ext  = {{16{~uns & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        misaligned = |addr_lo;
        wdata_lane = wdata;
        rdata_ext  = shifted;
      end
    endcase
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter sharing riscv_mem between instruction fetch and load/store,
// sequencing each access IDLE -> ACCESS -> RESP.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter bit RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic              ls_unsigned,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              ls_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_by,
  output logic [31:0]       mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  state_t            state_reg, state_next;
  logic              rr_ptr_reg;
  logic              owner_reg;
  logic              we_reg;
  logic [1:0]        size_reg;
  logic              uns_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       if_rdata_reg, ls_rdata_reg;
  logic              if_err_reg, ls_err_reg;

  logic              win_ls;
  logic              in_access;
  logic              mis;
  logic [31:0]       lane_wdata, lane_rdata, resp_data;

  riscv_mem_lane u_lane (
    .size       (size_reg),
    .uns        (uns_reg),
    .addr_lo    (addr_reg[1:0]),
    .wdata      (wdata_reg),
    .rdata_raw  (mem_rdata),
    .misaligned (mis),
    .wdata_lane (lane_wdata),
    .rdata_ext  (lane_rdata)
  );

  // LS wins when it is alone or when the pointer favours it on a tie.
  assign win_ls = ls_req & (~if_req | (rr_ptr_reg == REQ_LS));

  always_comb begin
    state_next = state_reg;
    if_gnt     = 1'b0;
    ls_gnt     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (if_req | ls_req) begin
          if_gnt     = ~win_ls;
          ls_gnt     = win_ls;
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_access = (state_reg == ACCESS);
  assign mem_addr  = in_access ? addr_reg : '0;
  assign mem_by    = in_access ? norm_size(size_reg) : 2'b00;
  assign mem_wdata = (in_access & we_reg) ? lane_wdata : 32'd0;
  assign mem_re    = in_access & ~we_reg & ~mis;
  assign mem_we    = in_access & we_reg & ~mis;
  assign resp_data = (mis | we_reg) ? 32'd0 : lane_rdata;

  assign if_rvalid = (state_reg == RESP) & (owner_reg == REQ_IF);
  assign ls_rvalid = (state_reg == RESP) & (owner_reg == REQ_LS);
  assign if_rdata  = if_rdata_reg;
  assign if_err    = if_err_reg;
  assign ls_rdata  = ls_rdata_reg;
  assign ls_err    = ls_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= RR_INIT;
      owner_reg    <= REQ_IF;
      we_reg       <= 1'b0;
      size_reg     <= SZ_BYTE;
      uns_reg      <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= 32'd0;
      if_rdata_reg <= 32'd0;
      if_err_reg   <= 1'b0;
      ls_rdata_reg <= 32'd0;
      ls_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && (if_req | ls_req)) begin
        owner_reg  <= win_ls;
        rr_ptr_reg <= ~win_ls;
        if (win_ls) begin
          we_reg    <= ls_we;
          size_reg  <= ls_size;
          uns_reg   <= ls_unsigned;
          addr_reg  <= ls_addr;
          wdata_reg <= ls_wdata;
        end else begin
          we_reg    <= 1'b0;
          size_reg  <= SZ_WORD;
          uns_reg   <= 1'b1;
          addr_reg  <= if_addr;
          wdata_reg <= 32'd0;
        end
      end
      // Response registers only change here, so rdata/err hold between accesses.
      if (in_access) begin
        if (owner_reg == REQ_LS) begin
          ls_rdata_reg <= resp_data;
          ls_err_reg   <= mis;
        end else begin
          if_rdata_reg <= resp_data;
          if_err_reg   <= mis;
        end
      end
    end
  end

endmodule
